// File: rtl/clm_cmul_seq.sv
// Sequential multi-lane multiplier by a runtime GF(2^8) coefficient on CLM code words:
// shift-and-add product over 8/UNROLL cycles, then masked reduction of the overflow through B_ext.
module clm_cmul_seq #(
    parameter int D      = 2,
    parameter int LANES  = 4,
    parameter int UNROLL = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*(8+D)-1:0] in_data,
    input  logic [LANES*D-1:0]     in_r,
    input  logic [7:0]             coef,
    input  logic [(D+7)*8-1:0]     B_ext,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*(8+D)-1:0] out_data
);
    localparam int N     = 8 + D;
    localparam int PW    = 15 + D;
    localparam int STEPS = 8 / UNROLL;
    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_RED, S_DONE} state_e;

    state_e                     state_q, state_d;
    logic                       en_q;
    logic [2:0]                 step_q, step_d;
    logic [7:0]                 coef_q, coef_d;
    logic [LANES-1:0][PW-1:0]   xs_q, xs_d;
    logic [LANES-1:0][PW-1:0]   acc_q, acc_d;
    logic [LANES-1:0][D-1:0]    r_q, r_d;
    logic [LANES-1:0][N-1:0]    out_q, out_d;
    logic [LANES-1:0][N-1:0]    in_lanes;
    logic [LANES-1:0][D-1:0]    r_lanes;
    logic                       accept;

    assign in_lanes = in_data;
    assign r_lanes  = in_r;
    assign accept   = in_valid && in_ready;
    assign out_data = out_q;

    // Overflow bits above degree N-1 and the refresh bits select rows of B_ext.
    function automatic logic [N-1:0] reduce_lane(input logic [PW-1:0]        p,
                                                 input logic [D-1:0]         r,
                                                 input logic [(D+7)*8-1:0]   b_ext);
        logic [D+6:0] v;
        logic [N-1:0] red;
        v   = {p[PW-1:N], r};
        red = '0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < D + 7; j++) begin
                red[k] = red[k] ^ (v[j] & b_ext[j*8 + k]);
            end
        end
        red[N-1:8] = r;
        return p[N-1:0] ^ red;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_MUL;
            S_MUL:   if (step_q == LAST_STEP) state_d = S_RED;
            S_RED:   state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && en_q;
        out_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= '0;
            coef_q <= '0;
            xs_q   <= '0;
            acc_q  <= '0;
            r_q    <= '0;
            out_q  <= '0;
        end else begin
            step_q <= step_d;
            coef_q <= coef_d;
            xs_q   <= xs_d;
            acc_q  <= acc_d;
            r_q    <= r_d;
            out_q  <= out_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        step_d = step_q;
        coef_d = coef_q;
        xs_d   = xs_q;
        acc_d  = acc_q;
        r_d    = r_q;
        out_d  = out_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    step_d = '0;
                    coef_d = coef;
                    acc_d  = '0;
                    r_d    = r_lanes;
                    for (int l = 0; l < LANES; l++) xs_d[l] = PW'(in_lanes[l]);
                end
            end
            S_MUL: begin
                // Operand and coefficient shift together, so bit u of coef_q always weights xs_q << u.
                for (int l = 0; l < LANES; l++) begin
                    for (int u = 0; u < UNROLL; u++) begin
                        if (coef_q[u]) acc_d[l] = acc_d[l] ^ (xs_q[l] << u);
                    end
                    xs_d[l] = xs_q[l] << UNROLL;
                end
                coef_d = coef_q >> UNROLL;
                step_d = step_q + 3'd1;
            end
            S_RED: begin
                for (int l = 0; l < LANES; l++) out_d[l] = reduce_lane(acc_q[l], r_q[l], B_ext);
            end
            default: ;
        endcase
    end

endmodule
